// File: rtl/blink_period_sched_if.sv
// ---------------------------------------------------------------------------
// blink_period_sched_if
//   Groups the button input and the blink/status outputs of
//   blink_period_sched into one bundle.
//
//   btn         debounced button level, 1 = pressed        (master -> slave)
//   led_out     blink output, 1 = second half of period    (slave -> master)
//   period_out  currently active period in clk cycles      (slave -> master)
//   applied     one-cycle pulse: a new period was committed
//   sat         one-cycle pulse: a halve was clamped/dropped at the floor
//   busy        a period-change request is pending
// ---------------------------------------------------------------------------
interface blink_period_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic             btn;
  logic             led_out;
  logic [WIDTH-1:0] period_out;
  logic             applied;
  logic             sat;
  logic             busy;

  // Master drives the button and observes the scheduler.
  modport master (
    output btn,
    input  led_out,
    input  period_out,
    input  applied,
    input  sat,
    input  busy
  );

  // Slave is the scheduler itself.
  modport slave (
    input  btn,
    output led_out,
    output period_out,
    output applied,
    output sat,
    output busy
  );
endinterface

// File: rtl/blink_period_sched.sv
// ---------------------------------------------------------------------------
// blink_period_sched
//   Turns a debounced button level into period-change requests and owns the
//   blink period counter. A short press halves the period (floored at
//   MIN_PERIOD); a long press restores DEFAULT_PERIOD. Changes are only
//   committed on the last cycle of a blink period so the LED never glitches.
//
//   clk    system clock
//   reset  synchronous, active-high reset
//   sched  blink_period_sched_if.slave:
//            btn (in), led_out, period_out, applied, sat, busy (out)
// ---------------------------------------------------------------------------
module blink_period_sched #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = 48000000,
  parameter int unsigned MIN_PERIOD     = 48,
  parameter int unsigned LONG_PRESS     = 48000000
) (
  input  logic                 clk,
  input  logic                 reset,
  blink_period_sched_if.slave  sched
);

  // Hold counter only needs to reach LONG_PRESS; it saturates at all-ones.
  localparam int unsigned HOLD_W = (LONG_PRESS < 2) ? 1 : $clog2(LONG_PRESS + 1);

  localparam logic [WIDTH-1:0]  P_DEFAULT = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0]  P_MIN     = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0]  P_ONE     = WIDTH'(1);
  localparam logic [HOLD_W-1:0] P_LONG    = HOLD_W'(LONG_PRESS);
  localparam logic [HOLD_W-1:0] P_HOLD1   = HOLD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HELD
  } state_t;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic              r_btn_q;
  logic              w_rise;
  logic              w_fall;

  state_t            r_state;
  state_t            w_state_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_next;
  logic              w_post_halve;
  logic              w_post_restore;
  logic              r_req_halve;
  logic              r_req_restore;

  logic              r_pend_restore;
  logic [1:0]        r_pend_shift;
  logic              w_pend_restore_next;
  logic [1:0]        w_pend_shift_next;
  logic              w_busy;

  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_period;
  logic [WIDTH-1:0]  w_cnt_next;
  logic [WIDTH-1:0]  w_period_next;
  logic [WIDTH-1:0]  w_shifted;
  logic [WIDTH-1:0]  w_new_period;
  logic              w_wrap;
  logic              w_commit;
  logic              w_clamp;

  logic              r_led;
  logic              r_applied;
  logic              r_sat;

  // -------------------------------------------------------------------------
  // Button edge detect. r_btn_q resets high so a button held through reset
  // release produces no rise until it has been released once.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_q <= 1'b1;
    end else begin
      r_btn_q <= sched.btn;
    end
  end

  assign w_rise = sched.btn & ~r_btn_q;
  assign w_fall = ~sched.btn & r_btn_q;

  // -------------------------------------------------------------------------
  // Press FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  // -------------------------------------------------------------------------
  // Press FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) w_state_next = S_PRESSED;
      end
      S_PRESSED: begin
        // A release on the very cycle the long press is reached goes straight
        // back to IDLE; otherwise HELD would wait for a fall already seen.
        if (r_hold_cnt >= P_LONG) w_state_next = w_fall ? S_IDLE : S_HELD;
        else if (w_fall)          w_state_next = S_IDLE;
      end
      S_HELD: begin
        if (w_fall) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Press FSM: outputs (hold counter update and request posting)
  // -------------------------------------------------------------------------
  always_comb begin
    w_hold_next    = r_hold_cnt;
    w_post_halve   = 1'b0;
    w_post_restore = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) w_hold_next = P_HOLD1;
      end
      S_PRESSED: begin
        if (r_hold_cnt != '1) w_hold_next = r_hold_cnt + P_HOLD1;
        // Long press wins over a simultaneous release.
        if (r_hold_cnt >= P_LONG) w_post_restore = 1'b1;
        else if (w_fall)          w_post_halve   = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered request pulses; these are what update the pending state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_halve   <= 1'b0;
      r_req_restore <= 1'b0;
    end else begin
      r_req_halve   <= w_post_halve;
      r_req_restore <= w_post_restore;
    end
  end

  // -------------------------------------------------------------------------
  // Blink counter and commit datapath
  // -------------------------------------------------------------------------
  assign w_busy   = r_pend_restore | (r_pend_shift != 2'd0);
  assign w_wrap   = (r_cnt == (r_period - P_ONE));
  assign w_commit = w_wrap & w_busy;

  assign w_shifted    = r_period >> r_pend_shift;
  assign w_clamp      = ~r_pend_restore & (w_shifted < P_MIN);
  assign w_new_period = r_pend_restore ? P_DEFAULT :
                        (w_clamp ? P_MIN : w_shifted);

  assign w_cnt_next    = w_wrap ? '0 : (r_cnt + P_ONE);
  assign w_period_next = w_commit ? w_new_period : r_period;

  // Pending state: a commit clears first, then a request arriving on the
  // same cycle is applied on top so it survives into the next period.
  always_comb begin
    w_pend_restore_next = w_commit ? 1'b0 : r_pend_restore;
    w_pend_shift_next   = w_commit ? 2'd0 : r_pend_shift;
    if (r_req_restore) begin
      w_pend_restore_next = 1'b1;
      w_pend_shift_next   = 2'd0;
    end else if (r_req_halve && !w_pend_restore_next) begin
      if (w_pend_shift_next != 2'd3) w_pend_shift_next = w_pend_shift_next + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_restore <= 1'b0;
      r_pend_shift   <= 2'd0;
      r_cnt          <= '0;
      r_period       <= P_DEFAULT;
      r_led          <= 1'b0;
      r_applied      <= 1'b0;
      r_sat          <= 1'b0;
    end else begin
      r_pend_restore <= w_pend_restore_next;
      r_pend_shift   <= w_pend_shift_next;
      r_cnt          <= w_cnt_next;
      r_period       <= w_period_next;
      // Computed from next-state values so the LED is low at cnt 0 of a
      // freshly committed period without a cycle of lag.
      r_led          <= (w_cnt_next >= (w_period_next >> 1));
      r_applied      <= w_commit & (w_new_period != r_period);
      r_sat          <= w_commit & w_clamp;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign sched.led_out    = r_led;
  assign sched.period_out = r_period;
  assign sched.applied    = r_applied;
  assign sched.sat        = r_sat;
  assign sched.busy       = w_busy;

endmodule

// File: tb/tb_blink_period_sched.sv
// ---------------------------------------------------------------------------
// tb_blink_period_sched
//   Drives directed and random button activity into blink_period_sched and
//   compares every cycle against a behavioural model of the press/commit rules.
// ---------------------------------------------------------------------------
module tb_blink_period_sched;

  localparam int unsigned W    = 8;
  localparam int          DEF  = 16;
  localparam int          MINP = 4;
  localparam int          LONG = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  blink_period_sched_if #(.WIDTH(W)) u_if ();

  blink_period_sched #(
    .WIDTH          (W),
    .DEFAULT_PERIOD (DEF),
    .MIN_PERIOD     (MINP),
    .LONG_PRESS     (LONG)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .sched (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model, advanced once per rising clock edge.
  //   m_phase  position inside the current blink period
  //   m_k      edges since the press began
  //   m_req    request decided at this edge, reaches pending at the next one
  //            (0 none, 1 halve, 2 restore)
  // -------------------------------------------------------------------------
  int m_period, m_phase, m_halves, m_k, m_req;
  bit m_restore, m_prev, m_in_press, m_applied, m_sat;

  task automatic model_step(input bit b, input bit r);
    int np;
    if (r) begin
      m_period = DEF; m_phase = 0; m_halves = 0; m_restore = 0;
      m_req = 0; m_prev = 1; m_in_press = 0; m_k = 0;
      m_applied = 0; m_sat = 0;
      return;
    end
    m_applied = 0;
    m_sat     = 0;
    if (m_phase == m_period - 1) begin
      if (m_restore || m_halves > 0) begin
        if (m_restore) np = DEF;
        else begin
          np = m_period >> m_halves;
          if (np < MINP) begin
            np    = MINP;
            m_sat = 1;
          end
        end
        m_applied = (np != m_period);
        m_period  = np;
        m_restore = 0;
        m_halves  = 0;
      end
      m_phase = 0;
    end else begin
      m_phase++;
    end
    if (m_req == 2) begin
      m_restore = 1;
      m_halves  = 0;
    end else if (m_req == 1 && !m_restore && m_halves < 3) begin
      m_halves++;
    end
    m_req = 0;
    if (m_in_press) begin
      m_k++;
      if (m_k >= LONG) begin
        m_req = 2;
        m_in_press = 0;
      end else if (!b) begin
        m_req = 1;
        m_in_press = 0;
      end
    end else if (b && !m_prev) begin
      m_in_press = 1;
      m_k = 0;
    end
    m_prev = b;
  endtask

  task automatic tick();
    bit b, r;
    b = u_if.btn;
    r = reset;
    @(posedge clk);
    model_step(b, r);
    #1;
    check("period_out", u_if.period_out, m_period);
    check("led_out",    u_if.led_out,    (m_phase >= m_period / 2) ? 1 : 0);
    check("applied",    u_if.applied,    m_applied);
    check("sat",        u_if.sat,        m_sat);
    check("busy",       u_if.busy,       (m_restore || m_halves != 0) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    u_if.btn = 1'b0;
    repeat (n) tick();
  endtask

  task automatic press(input int n);
    u_if.btn = 1'b1;
    repeat (n) tick();
    u_if.btn = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic idle_until_phase(input int p);
    u_if.btn = 1'b0;
    for (int i = 0; i < 40 && m_phase != p; i++) tick();
  endtask

  initial begin
    u_if.btn = 1'b0;

    // Idle blink
    do_reset(3);
    check("reset_period", u_if.period_out, DEF);
    idle(64);
    check("idle_period", u_if.period_out, DEF);

    // Single short press halves the period
    idle(5);
    press(3);
    idle(40);
    check("short_period", u_if.period_out, 8);

    // Three short presses in one period clamp to the floor
    do_reset(2);
    idle_until_phase(0);
    for (int i = 0; i < 3; i++) begin
      press(2);
      idle(1);
    end
    idle(20);
    check("triple_period", u_if.period_out, MINP);
    press(2);
    idle(20);
    check("floor_period", u_if.period_out, MINP);

    // Long press restores the default period
    press(15);
    idle(40);
    check("long_period", u_if.period_out, DEF);

    // Button held across reset release is ignored
    u_if.btn = 1'b1;
    do_reset(3);
    u_if.btn = 1'b1;
    repeat (20) tick();
    idle(5);
    check("held_reset_busy", u_if.busy, 0);
    press(3);
    idle(40);
    check("held_reset_short", u_if.period_out, 8);

    // Reset with a halve pending
    do_reset(2);
    idle_until_phase(2);
    press(3);
    idle(3);
    do_reset(1);
    check("rst_pend_busy", u_if.busy, 0);
    check("rst_pend_period", u_if.period_out, DEF);
    idle(20);

    // Random press/release traffic
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      idle($urandom_range(0, 20));
      if ($urandom_range(0, 4) == 0) press($urandom_range(8, 16));
      else                           press($urandom_range(1, 8));
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/blink_period_sched.md
# blink_period_sched

Scheduler for the LED blink datapath: turns a debounced user-button level into period-change commands and owns the blink period counter. It commits each change only at a blink-cycle boundary, so the LED output never glitches. It sits between the button debouncer and the RGB LED pins in the top level and replaces ad-hoc per-cycle period updates.

## Interface

Parameters:
- WIDTH, 32, width of period and counter datapath
- DEFAULT_PERIOD, 48000000, blink period in clk cycles after reset or restore (1 Hz at 48 MHz)
- MIN_PERIOD, 48, floor for halved periods; must satisfy 2 <= MIN_PERIOD <= DEFAULT_PERIOD
- LONG_PRESS, 48000000, hold length in cycles that counts as a long press

Ports:
- clk  in  1  system clock (clk48 at top level)
- reset  in  1  synchronous, active-high reset
- btn  in  1  debounced button level, 1 = pressed
- led_out  out  1  blink output, 1 = second half of period (top inverts for active-low LED)
- period_out  out  WIDTH  currently active period
- applied  out  1  one-cycle pulse: a new period was committed
- sat  out  1  one-cycle pulse: a halve request was clamped or dropped at MIN_PERIOD
- busy  out  1  a request is pending and not yet committed

## Operation

- **Edge detect.** `btn_q` is `btn` registered. `rise = btn & ~btn_q`; `fall = ~btn & btn_q`. `btn_q` resets to 1, so a button held through reset release is ignored until it is released.
- **Press FSM.**
  - IDLE: on `rise`, go to PRESSED and set `hold_cnt` = 1.
  - PRESSED: `hold_cnt` increments each cycle, saturating.
    - On `fall` with `hold_cnt` < LONG_PRESS: post a HALVE and go to IDLE.
    - When `hold_cnt` reaches LONG_PRESS: post a RESTORE (exactly once) and go to HELD.
  - HELD: stay until `fall`, then go to IDLE. No further request is posted.
- **Pending request.** Held in `pend_restore` (1 bit) and `pend_shift` (2 bits).
  - HALVE: `pend_shift` increments, saturating at 3. Ignored while `pend_restore` = 1.
  - RESTORE: sets `pend_restore` and clears `pend_shift`.
  - `busy = pend_restore | (pend_shift != 0)`.
- **Blink counter.** `cnt` runs 0..`period_out`-1 and wraps to 0. `led_out = (cnt >= period_out >> 1)`.
- **Commit.** Only on the wrap cycle (`cnt == period_out - 1`) with `busy` = 1:
  - RESTORE: new period = DEFAULT_PERIOD.
  - Otherwise: new period = `period_out >> pend_shift`. If the result is < MIN_PERIOD, use MIN_PERIOD and pulse `sat`.
  - If the new period equals the current one, `applied` stays 0. If that happens on a halve (already at MIN_PERIOD), `sat` still pulses.
  - Pending state is cleared on the commit cycle.
- **Request during commit.** A request posted on the same cycle as a commit survives into the next period. Priority: the clear happens first, then the new request is applied.
- **Width.** All comparisons are unsigned WIDTH-bit. Shifts are logical.

## Timing

- **Reset values:** FSM = IDLE, `hold_cnt` = 0, `cnt` = 0, `period_out` = DEFAULT_PERIOD, `led_out` = 0, `applied` = 0, `sat` = 0, `busy` = 0, pending cleared.
- **Reset mid-operation:** pending requests and partial presses are discarded. The blink restarts at `cnt` = 0.
- **Request posting:** a request is posted 2 cycles after the `btn` edge that causes it (1 cycle for `btn_q`, 1 for the FSM register). `busy` rises on the cycle after posting.
- **Commit cycle:** on the wrap cycle, the new period is registered, so `period_out` updates on the next cycle, at the same time as `cnt` = 0. `applied` and `sat` are registered and high for exactly that one cycle.
- **`led_out`:** registered from the next-state `cnt` and `period_out`. It is low at `cnt` = 0 of each period, with no extra latency.
- **Worst-case commit latency:** one full current period plus 2 cycles.
- **Long-press RESTORE:** posted at press cycle LONG_PRESS (plus the 2-cycle edge latency), regardless of when the button is released.

## Test plan

Parameters for all tests: DEFAULT_PERIOD = 16, MIN_PERIOD = 4, LONG_PRESS = 10, WIDTH = 8.

- **Idle blink:** reset, `btn` = 0 for 64 cycles -> `period_out` = 16; `led_out` is 0 for `cnt` 0–7 and 1 for `cnt` 8–15; `applied`, `sat` and `busy` never assert.
- **Short press:** 3-cycle press mid-period -> `busy` = 1 until the wrap; at the next boundary `period_out` = 8 and `applied` pulses once; `led_out` then toggles every 4 cycles.
- **Three short presses in one period:** `pend_shift` = 3 -> 16 >> 3 = 2 is clamped to 4; `period_out` = 4; `applied` and `sat` pulse together. A further short press -> `sat` pulses, `applied` stays 0, `period_out` stays 4.
- **Long press:** from `period_out` = 4, hold 15 cycles -> RESTORE is posted while still held; next boundary `period_out` = 16 and `applied` pulses; release posts nothing.
- **Button held across reset:** `btn` = 1 across reset deassertion for 20 cycles, then released -> no request and `busy` stays 0; a following short press halves normally.
- **Reset with pending request:** reset asserted with a HALVE pending at `cnt` = 9 -> after reset `period_out` = 16, `busy` = 0, `cnt` restarts at 0, no `applied` pulse.
